// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared types and constants for the writeback trace FIFO
//
// Contents:
//   REG_W        destination register index width
//   SEQ_W_DEF    default sequence tag width
//   XLEN_DEF     default PC / write-data width
//   wb_entry_t   one trace entry {seq, pc, wr, wd} at default widths
//   entry_width  packed entry width for arbitrary XLEN / SEQ_W
package wb_trace_pkg;

    localparam int REG_W     = 5;
    localparam int SEQ_W_DEF = 16;
    localparam int XLEN_DEF  = 32;

    typedef struct packed {
        logic [SEQ_W_DEF-1:0] seq;
        logic [XLEN_DEF-1:0]  pc;
        logic [REG_W-1:0]     wr;
        logic [XLEN_DEF-1:0]  wd;
    } wb_entry_t;

    // Field order in the packed entry matches wb_entry_t: seq, pc, wr, wd.
    function automatic int entry_width(input int xlen, input int seq_w);
        return seq_w + xlen + REG_W + xlen;
    endfunction

endpackage

// File: rtl/wb_trace_ram.sv
// rtl/wb_trace_ram.sv - DEPTH x entry flop array, one write port, one async read port
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address (FIFO tail)
//   wdata  in   entry to store
//   raddr  in   read address (FIFO head)
//   rdata  out  entry at raddr, combinational
module wb_trace_ram
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = $bits(wb_entry_t),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage is not reset; the top level masks the read data while empty.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - register-writeback trace buffer with sequence tags and drop accounting
//
// Optional feature: define WB_TRACE_FILTER_X0_EN to ignore writes to x0.
//
// Ports:
//   clk_i        in   core clock
//   reset_i      in   asynchronous active-low reset
//   cap_en_i     in   capture enable
//   rf_we_i      in   regfile write enable
//   rf_wr_i      in   destination register
//   rf_wd_i      in   write data
//   pc_i         in   PC of the writing instruction
//   out_valid_o  out  head entry valid
//   out_ready_i  in   consumer accepts the head entry
//   out_pc_o     out  head PC
//   out_wr_o     out  head destination register
//   out_wd_o     out  head write data
//   out_seq_o    out  head sequence tag
//   count_o      out  occupancy
//   overflow_o   out  sticky drop flag
//   drop_cnt_o   out  saturating dropped-event count
//   clr_ovf_i    in   clears overflow_o and drop_cnt_o
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = XLEN_DEF,
    parameter int SEQ_W = SEQ_W_DEF
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cap_en_i,
    input  logic                     rf_we_i,
    input  logic [REG_W-1:0]         rf_wr_i,
    input  logic [XLEN-1:0]          rf_wd_i,
    input  logic [XLEN-1:0]          pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [REG_W-1:0]         out_wr_o,
    output logic [XLEN-1:0]          out_wd_o,
    output logic [SEQ_W-1:0]         out_seq_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [SEQ_W-1:0]         drop_cnt_o,
    input  logic                     clr_ovf_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = entry_width(XLEN, SEQ_W);

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [SEQ_W-1:0] seq;
    logic             ovf;
    logic [SEQ_W-1:0] dcnt;

    logic             qualify;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;

    always_comb begin
        qualify = cap_en_i & rf_we_i;
`ifdef WB_TRACE_FILTER_X0_EN
        qualify = qualify & (rf_wr_i != '0);
`else
        qualify = qualify;
`endif
    end

    assign full = (count == CW'(DEPTH));
    assign pop  = (count != '0) & out_ready_i;
    // A pop frees the slot in the same cycle, so full + pop still accepts.
    assign push = qualify & (~full | pop);
    assign drop = qualify & full & ~pop;

    assign wdata = {seq, pc_i, rf_wr_i, rf_wd_i};

    wb_trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk   (clk_i),
        .we    (push),
        .waddr (tail),
        .wdata (wdata),
        .raddr (head),
        .rdata (rdata)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            seq   <= '0;
            ovf   <= 1'b0;
            dcnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // Tags advance on dropped events too, so drops show up as gaps.
            if (qualify) begin
                seq <= seq + 1'b1;
            end
            // A drop wins over a simultaneous clear: the new drop is counted.
            if (drop) begin
                ovf <= 1'b1;
                if (clr_ovf_i) begin
                    dcnt <= SEQ_W'(1);
                end else if (dcnt != '1) begin
                    dcnt <= dcnt + 1'b1;
                end
            end else if (clr_ovf_i) begin
                ovf  <= 1'b0;
                dcnt <= '0;
            end
        end
    end

    assign out_valid_o = (count != '0);
    assign count_o     = count;
    assign overflow_o  = ovf;
    assign drop_cnt_o  = dcnt;

    // Mask stale storage while empty so the outputs read zero after reset.
    assign {out_seq_o, out_pc_o, out_wr_o, out_wd_o} = out_valid_o ? rdata : '0;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb/tb_wb_trace_fifo.sv - scoreboard bench for wb_trace_fifo
module tb_wb_trace_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        cap_en_i;
    logic        rf_we_i;
    logic [4:0]  rf_wr_i;
    logic [31:0] rf_wd_i;
    logic [31:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_pc_o;
    logic [4:0]  out_wr_o;
    logic [31:0] out_wd_o;
    logic [15:0] out_seq_o;
    logic [3:0]  count_o;
    logic        overflow_o;
    logic [15:0] drop_cnt_o;
    logic        clr_ovf_i;

    wb_trace_fifo #(.DEPTH(DEPTH), .XLEN(32), .SEQ_W(16)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .cap_en_i    (cap_en_i),
        .rf_we_i     (rf_we_i),
        .rf_wr_i     (rf_wr_i),
        .rf_wd_i     (rf_wd_i),
        .pc_i        (pc_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pc_o    (out_pc_o),
        .out_wr_o    (out_wr_o),
        .out_wd_o    (out_wd_o),
        .out_seq_o   (out_seq_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .drop_cnt_o  (drop_cnt_o),
        .clr_ovf_i   (clr_ovf_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] seq;
        logic [31:0] pc;
        logic [4:0]  wr;
        logic [31:0] wd;
    } ev_t;

    ev_t         sb[$];
    int          m_count;
    logic [15:0] m_seq;
    logic        m_ovf;
    logic [15:0] m_dcnt;
    int          vectors;
    int          miscompares;
    int          max_count;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid_o), 64'(m_count != 0));
        chk("count", 64'(count_o), 64'(m_count));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(m_dcnt));
        if (m_count != 0) begin
            chk("head_seq", 64'(out_seq_o), 64'(sb[0].seq));
            chk("head_pc", 64'(out_pc_o), 64'(sb[0].pc));
            chk("head_wr", 64'(out_wr_o), 64'(sb[0].wr));
            chk("head_wd", 64'(out_wd_o), 64'(sb[0].wd));
        end else begin
            chk("empty_data", {out_seq_o, out_pc_o, out_wr_o, out_wd_o[10:0]}, 64'h0);
        end
        if (int'(count_o) > max_count) max_count = int'(count_o);
    endtask

    // One clock: drive at negedge, advance the model, check after the edge.
    task automatic cycle(input logic cap, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [31:0] pc,
                         input logic rdy, input logic clr);
        logic qual, pop, push, drop;
        @(negedge clk);
        cap_en_i = cap; rf_we_i = we; rf_wr_i = wr; rf_wd_i = wd; pc_i = pc;
        out_ready_i = rdy; clr_ovf_i = clr;
        qual = cap && we;
`ifdef WB_TRACE_FILTER_X0_EN
        qual = qual && (wr != 5'd0);
`endif
        pop  = (m_count != 0) && rdy;
        push = qual && ((m_count < DEPTH) || pop);
        drop = qual && (m_count == DEPTH) && !pop;
        if (pop) void'(sb.pop_front());
        if (push) sb.push_back('{m_seq, pc, wr, wd});
        if (qual) m_seq = m_seq + 16'd1;
        m_count = m_count + int'(push) - int'(pop);
        if (drop) begin
            m_ovf  = 1'b1;
            m_dcnt = clr ? 16'd1 : ((m_dcnt == 16'hffff) ? m_dcnt : m_dcnt + 16'd1);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_dcnt = 16'd0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic write(input logic [4:0] wr, input logic [31:0] wd,
                         input logic [31:0] pc, input logic rdy);
        cycle(1'b1, 1'b1, wr, wd, pc, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_seq   = 16'd0;
        m_ovf   = 1'b0;
        m_dcnt  = 16'd0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; max_count = 0;
        cap_en_i = 0; rf_we_i = 0; rf_wr_i = 0; rf_wd_i = 0; pc_i = 0;
        out_ready_i = 0; clr_ovf_i = 0;
        model_reset();

        // Reset state
        reset_i = 1'b0;
        #12;
        check_outputs();
        @(negedge clk);
        reset_i = 1'b1;

        // Three writes with consumer ready: in order, occupancy at most 1
        write(5'd5, 32'h11, 32'h0, 1'b1);
        write(5'd6, 32'h22, 32'h4, 1'b1);
        write(5'd7, 32'h33, 32'h8, 1'b1);
        idle(1'b1, 2);
        chk("max_count_streaming", 64'(max_count), 64'd1);

        // Overflow: DEPTH+2 writes with consumer stalled
        for (int i = 0; i < DEPTH + 2; i++)
            write(5'(i + 1), 32'h100 + 32'(i), 32'h1000 + 32'(4 * i), 1'b0);
        chk("ovf_count", 64'(count_o), 64'd8);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_drops", 64'(drop_cnt_o), 64'd2);
        idle(1'b1, DEPTH);
        write(5'd9, 32'hABCD, 32'h2000, 1'b0);
        chk("tag_after_drops", 64'(out_seq_o), 64'd13);
        idle(1'b1, 1);

        // Clear the sticky flag, refill, then sustained push+pop while full
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++)
            write(5'd10, 32'h200 + 32'(i), 32'h3000 + 32'(4 * i), 1'b0);
        for (int i = 0; i < 20; i++)
            write(5'd11, 32'h300 + 32'(i), 32'h4000 + 32'(4 * i), 1'b1);
        chk("full_stream_count", 64'(count_o), 64'd8);
        chk("full_stream_drops", 64'(drop_cnt_o), 64'd0);
        idle(1'b1, DEPTH);

        // x0 write, and a write with capture disabled
        write(5'd0, 32'hDEAD, 32'h5000, 1'b0);
`ifdef WB_TRACE_FILTER_X0_EN
        chk("x0_filtered", 64'(count_o), 64'd0);
`else
        chk("x0_captured_wr", 64'(out_wr_o), 64'd0);
`endif
        cycle(1'b0, 1'b1, 5'd3, 32'hBEEF, 32'h5004, 1'b0, 1'b0);
        idle(1'b1, 2);

        // Reset mid-drain with 5 entries
        for (int i = 0; i < 5; i++)
            write(5'd12, 32'h400 + 32'(i), 32'h6000 + 32'(4 * i), 1'b0);
        idle(1'b1, 1);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        model_reset();
        @(negedge clk);
        reset_i = 1'b1;
        write(5'd13, 32'h55, 32'h7000, 1'b0);
        chk("tag_after_reset", 64'(out_seq_o), 64'd0);
        idle(1'b1, 1);

        // Clear coinciding with a drop, then clear alone
        for (int i = 0; i < DEPTH; i++)
            write(5'd14, 32'h500 + 32'(i), 32'h8000 + 32'(4 * i), 1'b0);
        cycle(1'b1, 1'b1, 5'd15, 32'h600, 32'h9000, 1'b0, 1'b1);
        chk("clr_drop_flag", 64'(overflow_o), 64'd1);
        chk("clr_drop_cnt", 64'(drop_cnt_o), 64'd1);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("clr_alone_flag", 64'(overflow_o), 64'd0);
        chk("clr_alone_cnt", 64'(drop_cnt_o), 64'd0);
        idle(1'b1, DEPTH + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
